// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: turns START/STOP/ZERO/LAP pulses into clear/enable strobes
// for a four-digit BCD counter, prescales count ticks, saturates at 9999 and lap-freezes the display.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 50000,
    parameter int TICK_W   = 16
) (
    input  logic       clk_i,
    input  logic       clear_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       zero_i,
    input  logic       lap_i,
    input  logic [3:0] bcd3_i,
    input  logic [3:0] bcd2_i,
    input  logic [3:0] bcd1_i,
    input  logic [3:0] bcd0_i,
    output logic       cnt_clear_o,
    output logic       cnt_enable_o,
    output logic [3:0] disp3_o,
    output logic [3:0] disp2_o,
    output logic [3:0] disp1_o,
    output logic [3:0] disp0_o,
    output logic       running_o,
    output logic       ovf_o
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_OVF
    } state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   presc_q, presc_d;
    logic                freeze_q, freeze_d;
    logic                clear_q, clear_d;
    logic                enable_q, enable_d;
    logic [15:0]         disp_q, disp_d;
    logic                running_q, ovf_q;

    logic [15:0]         bcd_all;
    logic [3:0]          digit_is9;
    logic                at_max;

    assign bcd_all = {bcd3_i, bcd2_i, bcd1_i, bcd0_i};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit9
            assign digit_is9[gi] = (bcd_all[gi*4 +: 4] == 4'd9);
        end
    endgenerate

    assign at_max = &digit_is9;

    // Only the highest-priority asserted command (ZERO > STOP > START > LAP) acts.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        freeze_d = freeze_q;
        clear_d  = 1'b0;
        enable_d = 1'b0;
        case (state_q)
            S_INIT: begin
                state_d = S_IDLE;
            end
            S_RUN: begin
                if (zero_i) begin
                    state_d  = S_IDLE;
                    presc_d  = '0;
                    freeze_d = 1'b0;
                    clear_d  = 1'b1;
                end else if (stop_i) begin
                    // Prescaler holds so the fractional tick survives the pause.
                    state_d = S_PAUSED;
                end else begin
                    if (!start_i && lap_i) begin
                        freeze_d = ~freeze_q;
                    end
                    if (presc_q == TICK_LAST) begin
                        presc_d = '0;
                        if (at_max) begin
                            state_d = S_OVF;
                        end else begin
                            enable_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + TICK_W'(1);
                    end
                end
            end
            S_IDLE, S_PAUSED: begin
                if (zero_i) begin
                    state_d  = S_IDLE;
                    presc_d  = '0;
                    freeze_d = 1'b0;
                    clear_d  = 1'b1;
                end else if (stop_i) begin
                    state_d = state_q;
                end else if (start_i) begin
                    state_d = S_RUN;
                end else if (lap_i) begin
                    freeze_d = 1'b0;
                end
            end
            S_OVF: begin
                if (zero_i) begin
                    state_d  = S_IDLE;
                    presc_d  = '0;
                    freeze_d = 1'b0;
                    clear_d  = 1'b1;
                end else if (!stop_i && !start_i && lap_i) begin
                    freeze_d = 1'b0;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Display follows the counter except while the freeze flag stays set across the edge.
    assign disp_d = (freeze_q && freeze_d) ? disp_q : bcd_all;

    always_ff @(posedge clk_i or posedge clear_i) begin
        if (clear_i) begin
            state_q   <= S_INIT;
            presc_q   <= '0;
            freeze_q  <= 1'b0;
            clear_q   <= 1'b1;
            enable_q  <= 1'b0;
            disp_q    <= '0;
            running_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            freeze_q  <= freeze_d;
            clear_q   <= clear_d;
            enable_q  <= enable_d;
            disp_q    <= disp_d;
            running_q <= (state_d == S_RUN);
            ovf_q     <= (state_d == S_OVF);
        end
    end

    assign cnt_clear_o  = clear_q;
    assign cnt_enable_o = enable_q;
    assign disp3_o      = disp_q[15:12];
    assign disp2_o      = disp_q[11:8];
    assign disp1_o      = disp_q[7:4];
    assign disp0_o      = disp_q[3:0];
    assign running_o    = running_q;
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: an integer-valued counter stands in for the BCD counter and a
// mode/phase reference model predicts every registered output each cycle.
module tb_stopwatch_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       clear_i;
    logic       start_i, stop_i, zero_i, lap_i;
    logic [3:0] bcd3, bcd2, bcd1, bcd0;
    logic       cnt_clear_o, cnt_enable_o, running_o, ovf_o;
    logic [3:0] disp3_o, disp2_o, disp1_o, disp0_o;

    int cnt;
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: which mode the stopwatch is in, elapsed cycles toward the next tick,
    // lap freeze, and the predicted registered outputs.
    bit m_init, m_run, m_paused, m_ovf, m_frozen;
    int m_frac;
    bit e_clr, e_en;
    int e_disp;

    assign bcd3 = 4'((cnt / 1000) % 10);
    assign bcd2 = 4'((cnt / 100) % 10);
    assign bcd1 = 4'((cnt / 10) % 10);
    assign bcd0 = 4'(cnt % 10);

    always #5 clk = ~clk;

    stopwatch_ctrl #(.TICK_DIV(TD), .TICK_W(4)) dut (
        .clk_i        (clk),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .zero_i       (zero_i),
        .lap_i        (lap_i),
        .bcd3_i       (bcd3),
        .bcd2_i       (bcd2),
        .bcd1_i       (bcd1),
        .bcd0_i       (bcd0),
        .cnt_clear_o  (cnt_clear_o),
        .cnt_enable_o (cnt_enable_o),
        .disp3_o      (disp3_o),
        .disp2_o      (disp2_o),
        .disp1_o      (disp1_o),
        .disp0_o      (disp0_o),
        .running_o    (running_o),
        .ovf_o        (ovf_o)
    );

    function automatic int disp_val();
        return int'(disp3_o) * 1000 + int'(disp2_o) * 100 + int'(disp1_o) * 10 + int'(disp0_o);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_init   = 1'b1;
        m_run    = 1'b0;
        m_paused = 1'b0;
        m_ovf    = 1'b0;
        m_frozen = 1'b0;
        m_frac   = 0;
        e_clr    = 1'b1;
        e_en     = 1'b0;
        e_disp   = 0;
    endtask

    task automatic check_outputs();
        check_val("cnt_clear",  32'(cnt_clear_o),  32'(e_clr));
        check_val("cnt_enable", 32'(cnt_enable_o), 32'(e_en));
        check_val("running",    32'(running_o),    32'(m_run));
        check_val("ovf",        32'(ovf_o),        32'(m_ovf));
        check_val("disp",       32'(disp_val()),   32'(e_disp));
    endtask

    // One clock: check at the falling edge, drive commands, predict, cross the rising edge.
    task automatic cycle(input bit st, input bit sp, input bit z, input bit lp, input int preload = -1);
        bit n_run, n_paused, n_ovf, n_frozen, n_clr, n_en, idle;
        int n_frac, n_disp, cnt_next;
        check_outputs();
        start_i = st;
        stop_i  = sp;
        zero_i  = z;
        lap_i   = lp;
        if (st || sp || z || lp)
            $display("cycle %0d: start=%0b stop=%0b zero=%0b lap=%0b count=%0d", cyc, st, sp, z, lp, cnt);

        n_run = m_run; n_paused = m_paused; n_ovf = m_ovf; n_frozen = m_frozen;
        n_frac = m_frac; n_clr = 1'b0; n_en = 1'b0;
        idle = !m_init && !m_run && !m_paused && !m_ovf;
        if (m_init) begin
            n_run = 1'b0; n_paused = 1'b0; n_ovf = 1'b0;
        end else if (z) begin
            n_run = 1'b0; n_paused = 1'b0; n_ovf = 1'b0;
            n_frac = 0; n_frozen = 1'b0; n_clr = 1'b1;
        end else begin
            if (sp) begin
                if (m_run) begin n_run = 1'b0; n_paused = 1'b1; end
            end else if (st) begin
                if (idle || m_paused) begin n_run = 1'b1; n_paused = 1'b0; end
            end else if (lp) begin
                n_frozen = m_run ? !m_frozen : 1'b0;
            end
            if (m_run && !sp) begin
                if (m_frac == TD - 1) begin
                    n_frac = 0;
                    if (cnt == 9999) begin n_run = 1'b0; n_ovf = 1'b1; end
                    else n_en = 1'b1;
                end else begin
                    n_frac = m_frac + 1;
                end
            end
        end
        n_disp = (m_frozen && n_frozen) ? e_disp : cnt;

        if (cnt_clear_o) cnt_next = 0;
        else if (cnt_enable_o && cnt < 9999) cnt_next = cnt + 1;
        else cnt_next = cnt;
        if (preload >= 0) cnt_next = preload;

        @(posedge clk);
        #1;
        cnt = cnt_next;
        m_init = 1'b0; m_run = n_run; m_paused = n_paused; m_ovf = n_ovf;
        m_frozen = n_frozen; m_frac = n_frac;
        e_clr = n_clr; e_en = n_en; e_disp = n_disp;
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0);
    endtask

    initial begin
        clear_i = 1'b1;
        start_i = 1'b0; stop_i = 1'b0; zero_i = 1'b0; lap_i = 1'b0;
        cnt = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        clear_i = 1'b0;

        // Reset release and idle.
        idle_cycles(20);

        // Run cadence: ten ticks.
        cycle(1, 0, 0, 0);
        idle_cycles(42);
        check_val("disp_after_10_ticks", 32'(disp_val()), 32'd10);
        check_val("running_after_10",    32'(running_o),  32'd1);

        // Pause two cycles after a tick, resume.
        for (int k = 0; k < 10 && !cnt_enable_o; k++) cycle(0, 0, 0, 0);
        check_val("saw_tick", 32'(cnt_enable_o), 32'd1);
        idle_cycles(2);
        cycle(0, 1, 0, 0);
        idle_cycles(10);
        cycle(1, 0, 0, 0);
        idle_cycles(8);

        // Saturation from 9998.
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0, 9998);
        cycle(1, 0, 0, 0);
        idle_cycles(12);
        check_val("ovf_set",      32'(ovf_o),       32'd1);
        check_val("disp_at_9999", 32'(disp_val()),  32'd9999);
        cycle(1, 0, 0, 0);
        idle_cycles(6);
        cycle(0, 0, 1, 0);
        idle_cycles(2);
        check_val("disp_zeroed", 32'(disp_val()), 32'd0);

        // Lap freeze at 7, release at 15.
        cycle(1, 0, 0, 0);
        for (int k = 0; k < 200 && cnt != 7; k++) cycle(0, 0, 0, 0);
        check_val("reach_7", 32'(cnt), 32'd7);
        idle_cycles(1);
        cycle(0, 0, 0, 1);
        for (int k = 0; k < 200 && cnt != 15; k++) cycle(0, 0, 0, 0);
        check_val("lap_hold_7", 32'(disp_val()), 32'd7);
        cycle(0, 0, 0, 1);
        check_val("lap_release_15", 32'(disp_val()), 32'd15);

        // Simultaneous commands.
        idle_cycles(3);
        cycle(1, 1, 0, 0);
        check_val("stop_beats_start", 32'(running_o), 32'd0);
        cycle(1, 0, 1, 0);
        check_val("zero_beats_start", 32'(cnt_clear_o), 32'd1);
        idle_cycles(2);

        // Asynchronous clear mid-run.
        cycle(1, 0, 0, 0);
        idle_cycles(9);
        clear_i = 1'b1;
        #1;
        check_val("async_running",   32'(running_o),    32'd0);
        check_val("async_cnt_clear", 32'(cnt_clear_o),  32'd1);
        check_val("async_disp",      32'(disp_val()),   32'd0);
        @(posedge clk);
        #1;
        cnt = 0;
        @(negedge clk);
        clear_i = 1'b0;
        model_reset();
        idle_cycles(3);

        // Randomized commands with occasional preloads near saturation.
        for (int k = 0; k < 2000; k++) begin
            bit st, sp, z, lp;
            int pre;
            st = ($urandom_range(0, 11) == 0);
            sp = ($urandom_range(0, 29) == 0);
            z  = ($urandom_range(0, 59) == 0);
            lp = ($urandom_range(0, 15) == 0);
            pre = ($urandom_range(0, 199) == 0) ? 9990 + int'($urandom_range(0, 9)) : -1;
            cycle(st, sp, z, lp, pre);
        end
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
